// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word fetches and
// presents each returned word to the decoder through a one-entry valid/ready skid register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instruction_word,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_err
);

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_pending_pc, w_pending_pc_next;
  logic [31:0] r_word, w_word_next;
  logic [31:0] r_instr_pc, w_instr_pc_next;
  logic [7:0]  r_wait_cnt, w_wait_cnt_next;
  logic        r_err, w_err_next;

  logic [31:0] w_target;
  logic        w_req;
  logic        w_ack;
  logic        w_handshake;

  assign w_target    = {i_redirect_pc[31:2], 2'b00};
  assign w_req       = (r_state == StFetch) || (r_state == StDrain);
  // An ack with no request outstanding is ignored.
  assign w_ack       = w_req && i_imem_ack;
  assign w_handshake = (r_state == StHold) && i_instr_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: w_state_next = StFetch;
      StFetch: begin
        if (w_ack) begin
          w_state_next = i_redirect_valid ? StFetch : StHold;
        end else if (i_redirect_valid) begin
          w_state_next = StDrain;
        end
      end
      StHold: begin
        if (i_redirect_valid || w_handshake) begin
          w_state_next = StFetch;
        end
      end
      StDrain: begin
        if (w_ack) begin
          w_state_next = StFetch;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic: decoded from state and registers only
  always_comb begin
    o_imem_req         = w_req;
    o_imem_addr        = r_pc;
    o_instr_valid      = (r_state == StHold);
    o_instruction_word = r_word;
    o_instr_pc         = r_instr_pc;
    o_fetch_err        = r_err;
  end

  // Datapath next values
  always_comb begin
    w_pc_next         = r_pc;
    w_pending_pc_next = r_pending_pc;
    w_word_next       = r_word;
    w_instr_pc_next   = r_instr_pc;
    unique case (r_state)
      StIdle: begin
        if (i_redirect_valid) begin
          w_pc_next = w_target;
        end
      end
      StFetch: begin
        if (w_ack && i_redirect_valid) begin
          w_pc_next = w_target;
        end else if (w_ack) begin
          w_word_next     = i_imem_rdata;
          w_instr_pc_next = r_pc;
        end else if (i_redirect_valid) begin
          w_pending_pc_next = w_target;
        end
      end
      StHold: begin
        // A redirect wins over pc+4 even when the word is consumed in the same cycle.
        if (i_redirect_valid) begin
          w_pc_next = w_target;
        end else if (w_handshake) begin
          w_pc_next = r_pc + 32'd4;
        end
      end
      StDrain: begin
        if (i_redirect_valid) begin
          w_pending_pc_next = w_target;
        end
        if (w_ack) begin
          w_pc_next = i_redirect_valid ? w_target : r_pending_pc;
        end
      end
      default: w_pc_next = r_pc;
    endcase
  end

  // Wait counter restarts with every new request and saturates at the timeout.
  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if (!w_req || w_ack || (w_state_next != r_state)) begin
      w_wait_cnt_next = 8'd0;
    end else if (r_wait_cnt != TimeoutVal) begin
      w_wait_cnt_next = r_wait_cnt + 8'd1;
    end
    w_err_next = r_err || (w_wait_cnt_next == TimeoutVal);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_pending_pc <= RESET_PC;
      r_word       <= 32'd0;
      r_instr_pc   <= 32'd0;
      r_wait_cnt   <= 8'd0;
      r_err        <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_pending_pc <= w_pending_pc_next;
      r_word       <= w_word_next;
      r_instr_pc   <= w_instr_pc_next;
      r_wait_cnt   <= w_wait_cnt_next;
      r_err        <= w_err_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: one instance from address 0, one from the top
// of the address space to exercise PC wrap.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ack, ack_b;
  logic [31:0] rdata, rdata_b;
  logic        ready, ready_b;
  logic        redir;
  logic [31:0] redir_pc;

  logic        req, req_b;
  logic [31:0] addr, addr_b;
  logic [31:0] word, word_b;
  logic [31:0] ipc, ipc_b;
  logic        valid, valid_b;
  logic        err, err_b;

  logic        redir_b = 1'b0;
  logic [31:0] redir_pc_b = 32'd0;

  int n_total = 0;
  int n_bad   = 0;
  int n_xfer  = 0;
  int x0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .o_imem_req         (req),
    .o_imem_addr        (addr),
    .i_imem_ack         (ack),
    .i_imem_rdata       (rdata),
    .o_instruction_word (word),
    .o_instr_pc         (ipc),
    .o_instr_valid      (valid),
    .i_instr_ready      (ready),
    .i_redirect_valid   (redir),
    .i_redirect_pc      (redir_pc),
    .o_fetch_err        (err)
  );

  instruction_fetch_unit #(
    .RESET_PC       (32'hFFFF_FFFC),
    .TIMEOUT_CYCLES (16)
  ) u_dut_wrap (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .o_imem_req         (req_b),
    .o_imem_addr        (addr_b),
    .i_imem_ack         (ack_b),
    .i_imem_rdata       (rdata_b),
    .o_instruction_word (word_b),
    .o_instr_pc         (ipc_b),
    .o_instr_valid      (valid_b),
    .i_instr_ready      (ready_b),
    .i_redirect_valid   (redir_b),
    .i_redirect_pc      (redir_pc_b),
    .o_fetch_err        (err_b)
  );

  always @(posedge clk) begin
    if (rst_n && valid && ready) n_xfer <= n_xfer + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; rdata = '0; ready = 1'b0; redir = 1'b0; redir_pc = '0;
    ack_b = 1'b0; rdata_b = '0; ready_b = 1'b0;
    repeat (3) cyc();
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_word", word, 32'd0);
    check_eq("rst_ipc", ipc, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_addr_b", addr_b, 32'hFFFF_FFFC);

    // First fetch, acked in the first request cycle
    rst_n = 1'b1;
    cyc();
    check_eq("first_req", 32'(req), 32'd1);
    check_eq("first_addr", addr, 32'd0);
    check_eq("first_addr_b", addr_b, 32'hFFFF_FFFC);
    ack = 1'b1; rdata = 32'h00F6_F6E3; ack_b = 1'b1; rdata_b = 32'h1234_5678;
    cyc();
    check_eq("first_valid", 32'(valid), 32'd1);
    check_eq("first_ipc", ipc, 32'd0);
    check_eq("first_word", word, 32'h00F6_F6E3);
    check_eq("hold_no_req", 32'(req), 32'd0);
    check_eq("wrap_ipc", ipc_b, 32'hFFFF_FFFC);
    ack = 1'b0; ack_b = 1'b0; ready = 1'b1; ready_b = 1'b1;
    cyc();
    check_eq("seq1_valid", 32'(valid), 32'd0);
    check_eq("seq1_addr", addr, 32'd4);
    check_eq("wrap_addr", addr_b, 32'd0);
    check_eq("wrap_req", 32'(req_b), 32'd1);
    ready_b = 1'b0;

    // Second word stalls four cycles
    ready = 1'b0; ack = 1'b1; rdata = 32'hA1A1_0001;
    cyc();
    check_eq("seq1_ipc", ipc, 32'd4);
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("stall_valid", 32'(valid), 32'd1);
      check_eq("stall_word", word, 32'hA1A1_0001);
      check_eq("stall_ipc", ipc, 32'd4);
      check_eq("stall_req", 32'(req), 32'd0);
    end
    ready = 1'b1;
    cyc();
    check_eq("seq2_addr", addr, 32'd8);
    ready = 1'b0; ack = 1'b1; rdata = 32'hA2A2_0002;
    cyc();
    check_eq("seq2_ipc", ipc, 32'd8);
    check_eq("seq2_word", word, 32'hA2A2_0002);
    ack = 1'b0; ready = 1'b1;
    cyc();
    check_eq("seq3_addr", addr, 32'hC);
    ready = 1'b0;

    // Redirect while a fetch is outstanding
    redir = 1'b1; redir_pc = 32'h0000_0103;
    cyc();
    redir = 1'b0;
    check_eq("drain_req", 32'(req), 32'd1);
    check_eq("drain_addr", addr, 32'hC);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_eq("drain_wait_addr", addr, 32'hC);
    end
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    cyc();
    check_eq("drain_discard", 32'(valid), 32'd0);
    check_eq("drain_new_addr", addr, 32'h100);
    rdata = 32'hB0B0_0100;
    cyc();
    check_eq("redir_ipc", ipc, 32'h100);
    check_eq("redir_word", word, 32'hB0B0_0100);
    ack = 1'b0;

    // Redirect in HOLD without handshake
    redir = 1'b1; redir_pc = 32'h200;
    cyc();
    redir = 1'b0;
    check_eq("hold_drop_valid", 32'(valid), 32'd0);
    check_eq("hold_drop_addr", addr, 32'h200);
    ack = 1'b1; rdata = 32'hC0C0_0200;
    cyc();
    ack = 1'b0;
    check_eq("hold2_ipc", ipc, 32'h200);

    // Redirect in HOLD with simultaneous handshake
    x0 = n_xfer;
    ready = 1'b1; redir = 1'b1; redir_pc = 32'h200;
    cyc();
    ready = 1'b0; redir = 1'b0;
    check_eq("hold_hs_xfer", 32'(n_xfer - x0), 32'd1);
    check_eq("hold_hs_addr", addr, 32'h200);
    check_eq("hold_hs_valid", 32'(valid), 32'd0);

    // Redirect in FETCH with ack in the same cycle
    ack = 1'b1; rdata = 32'hE0E0_0000; redir = 1'b1; redir_pc = 32'h406;
    cyc();
    ack = 1'b0; redir = 1'b0;
    check_eq("fetch_ack_redir_valid", 32'(valid), 32'd0);
    check_eq("fetch_ack_redir_addr", addr, 32'h404);

    // Newest redirect wins while draining
    redir = 1'b1; redir_pc = 32'h500;
    cyc();
    redir_pc = 32'h600;
    cyc();
    redir = 1'b0; ack = 1'b1;
    cyc();
    ack = 1'b0;
    check_eq("drain_overwrite_addr", addr, 32'h600);
    check_eq("drain_overwrite_valid", 32'(valid), 32'd0);

    // Timeout: 15 unacked cycles are not enough, the 16th sets the flag
    repeat (15) cyc();
    check_eq("timeout_early", 32'(err), 32'd0);
    cyc();
    check_eq("timeout_set", 32'(err), 32'd1);
    check_eq("timeout_still_req", 32'(req), 32'd1);
    ack = 1'b1; rdata = 32'hF0F0_0600;
    cyc();
    ack = 1'b0;
    check_eq("late_ack_ipc", ipc, 32'h600);
    repeat (3) cyc();
    check_eq("err_sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("err_cleared", 32'(err), 32'd0);
    check_eq("async_rst_valid", 32'(valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
